// File: rtl/uart_baud_gen.sv
// Baud tick generator: os_tick_o every divisor period, bit_tick_o every OVS os ticks.
// Macro UART_BAUD_FRAC_EN builds the fractional accumulator; without it the fraction reads 0.
module uart_baud_gen #(
  parameter int CNT_W        = 16,
  parameter int FRAC_W       = 4,
  parameter int OVS          = 16,
  parameter int DEFAULT_INT  = 27,
  parameter int DEFAULT_FRAC = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              div_wr_i,
  input  logic [CNT_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  input  logic              baud_enable_i,
  input  logic              rx_mode_i,
  output logic              os_tick_o,
  output logic              bit_tick_o,
  output logic [CNT_W-1:0]  div_int_cur_o,
  output logic [FRAC_W-1:0] div_frac_cur_o,
  output logic              update_pending_o
);

  localparam int OVS_W = $clog2(OVS);

  logic              enPrev_q;
  logic [CNT_W-1:0]  prescale_q, prescale_d;
  logic [OVS_W-1:0]  osCnt_q, osCnt_d, osCntNow;
  logic [CNT_W-1:0]  divInt_q, divInt_d;
  logic [CNT_W-1:0]  shadowInt_q, shadowInt_d;
  logic              pending_q, pending_d;

  logic              rise, wrAtRise, carryNow, periodLast;
  logic              applyInput, applyShadow, captureShadow;
  logic [CNT_W-1:0]  intSel, intEff;
  logic [CNT_W:0]    periodM1;

  // A write on the enable-rise cycle already governs the first period, hence the bypass.
  assign rise      = baud_enable_i & ~enPrev_q;
  assign wrAtRise  = div_wr_i & rise;
  assign intSel    = wrAtRise ? div_int_i : divInt_q;
  assign intEff    = (intSel == '0) ? CNT_W'(1) : intSel;
  assign periodM1  = {1'b0, intEff} + {{CNT_W{1'b0}}, carryNow} - (CNT_W+1)'(1);
  assign periodLast = ({1'b0, prescale_q} == periodM1);
  assign osCntNow  = rise ? (rx_mode_i ? OVS_W'(OVS/2) : '0) : osCnt_q;

  assign os_tick_o  = baud_enable_i & ~reset_i & periodLast;
  assign bit_tick_o = os_tick_o & (osCntNow == OVS_W'(OVS-1));

  assign applyInput    = div_wr_i & (~baud_enable_i | rise | bit_tick_o);
  assign captureShadow = div_wr_i & ~applyInput;
  assign applyShadow   = ~div_wr_i & pending_q & (~baud_enable_i | bit_tick_o);

  assign div_int_cur_o    = divInt_q;
  assign update_pending_o = pending_q;

  always_comb begin
    prescale_d  = '0;
    osCnt_d     = '0;
    divInt_d    = divInt_q;
    shadowInt_d = shadowInt_q;
    pending_d   = pending_q;
    if (baud_enable_i) begin
      prescale_d = periodLast ? '0 : prescale_q + CNT_W'(1);
      osCnt_d    = osCntNow + OVS_W'(os_tick_o);
    end
    if (applyInput) begin
      divInt_d  = div_int_i;
      pending_d = 1'b0;
    end else if (applyShadow) begin
      divInt_d  = shadowInt_q;
      pending_d = 1'b0;
    end else if (captureShadow) begin
      shadowInt_d = div_int_i;
      pending_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      enPrev_q    <= 1'b0;
      prescale_q  <= '0;
      osCnt_q     <= '0;
      divInt_q    <= CNT_W'(DEFAULT_INT);
      shadowInt_q <= '0;
      pending_q   <= 1'b0;
    end else begin
      enPrev_q    <= baud_enable_i;
      prescale_q  <= prescale_d;
      osCnt_q     <= osCnt_d;
      divInt_q    <= divInt_d;
      shadowInt_q <= shadowInt_d;
      pending_q   <= pending_d;
    end
  end

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W-1:0] divFrac_q, divFrac_d;
  logic [FRAC_W-1:0] shadowFrac_q, shadowFrac_d;
  logic [FRAC_W-1:0] fracSel;
  logic [FRAC_W:0]   fracSum;
  logic              perCarry_q, perCarry_d;

  // The carry is decided once at period start and held for the rest of that period.
  assign fracSel  = wrAtRise ? div_frac_i : divFrac_q;
  assign fracSum  = {1'b0, acc_q} + {1'b0, fracSel};
  assign carryNow = (prescale_q == '0) ? fracSum[FRAC_W] : perCarry_q;
  assign div_frac_cur_o = divFrac_q;

  always_comb begin
    acc_d        = '0;
    perCarry_d   = 1'b0;
    divFrac_d    = divFrac_q;
    shadowFrac_d = shadowFrac_q;
    if (baud_enable_i) begin
      acc_d      = acc_q;
      perCarry_d = perCarry_q;
      if (prescale_q == '0) begin
        acc_d      = fracSum[FRAC_W-1:0];
        perCarry_d = fracSum[FRAC_W];
      end
    end
    if (applyInput)         divFrac_d    = div_frac_i;
    else if (applyShadow)   divFrac_d    = shadowFrac_q;
    else if (captureShadow) shadowFrac_d = div_frac_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_q        <= '0;
      perCarry_q   <= 1'b0;
      divFrac_q    <= FRAC_W'(DEFAULT_FRAC);
      shadowFrac_q <= '0;
    end else begin
      acc_q        <= acc_d;
      perCarry_q   <= perCarry_d;
      divFrac_q    <= divFrac_d;
      shadowFrac_q <= shadowFrac_d;
    end
  end
`else
  logic unusedFrac;

  assign carryNow       = 1'b0;
  assign div_frac_cur_o = '0;
  assign unusedFrac     = ^{div_frac_i, FRAC_W'(DEFAULT_FRAC)};
`endif

endmodule
